// File: rtl/unipolar_rz_pkg.sv
// Shared lane state type and elaboration-time helpers
// for the multi-lane unipolar return-to-zero transmitter.
package unipolar_rz_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LATCH
    } rz_state_t;

    function automatic int time_to_cycles(real rate, real t);
        return $rtoi(rate * t + 0.5);
    endfunction

    function automatic int max_count(
        int a,
        int b,
        int c,
        int d,
        int e
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/unipolar_rz_lane.sv
// One output lane: word FIFO, serializer, phase counter and
// IDLE/HIGH/LOW/LATCH sequencer.
module unipolar_rz_lane
    import unipolar_rz_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int T0H        = 40,
    parameter int T0L        = 85,
    parameter int T1H        = 80,
    parameter int T1L        = 45,
    parameter int TRST       = 5000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    output logic                  line,
    output logic                  idle
);

    localparam int CW = $clog2(max_count(T0H, T0L, T1H, T1L, TRST) + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    // Counters run from count-1 down to 0, so each phase spans count clocks.
    localparam logic [CW-1:0] L_T0H  = CW'(T0H - 1);
    localparam logic [CW-1:0] L_T0L  = CW'(T0L - 1);
    localparam logic [CW-1:0] L_T1H  = CW'(T1H - 1);
    localparam logic [CW-1:0] L_T1L  = CW'(T1L - 1);
    localparam logic [CW-1:0] L_TRST = CW'(TRST - 1);
    localparam logic [BW-1:0] L_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [AW:0]   L_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_count;

    rz_state_t             r_state;
    rz_state_t             w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nx;
    logic [BW-1:0]         r_bit;
    logic [BW-1:0]         w_bit_nx;
    logic                  r_line;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic                  w_head_bit;
    logic                  w_cur_bit;
    logic                  w_next_bit;

    assign ready      = (r_count != L_FULL);
    assign w_empty    = (r_count == '0);
    assign w_push     = valid && ready;
    assign w_head     = r_mem[r_rptr];
    assign w_shifted  = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
    assign w_head_bit = MSB_FIRST ? w_head[DATA_WIDTH-1] : w_head[0];
    assign w_cur_bit  = MSB_FIRST ? r_shift[DATA_WIDTH-1] : r_shift[0];
    assign w_next_bit = MSB_FIRST ? w_shifted[DATA_WIDTH-1] : w_shifted[0];
    assign line       = r_line;
    assign idle       = (r_state == IDLE) && w_empty;

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wptr] <= data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_pop      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_bit_nx   = L_LAST;
                    w_cnt_nx   = w_head_bit ? L_T1H : L_T0H;
                    w_state_nx = HIGH;
                end
            end
            HIGH: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else begin
                    w_cnt_nx   = w_cur_bit ? L_T1L : L_T0L;
                    w_state_nx = LOW;
                end
            end
            LOW: begin
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - 1'b1;
                end else if (r_bit != '0) begin
                    w_shift_nx = w_shifted;
                    w_bit_nx   = r_bit - 1'b1;
                    w_cnt_nx   = w_next_bit ? L_T1H : L_T0H;
                    w_state_nx = HIGH;
                end else if (!w_empty) begin
                    // Next word starts without a gap.
                    w_pop      = 1'b1;
                    w_shift_nx = w_head;
                    w_bit_nx   = L_LAST;
                    w_cnt_nx   = w_head_bit ? L_T1H : L_T0H;
                    w_state_nx = HIGH;
                end else begin
                    w_shift_nx = '0;
                    w_cnt_nx   = L_TRST;
                    w_state_nx = LATCH;
                end
            end
            LATCH: begin
                if (r_cnt != '0) w_cnt_nx = r_cnt - 1'b1;
                else             w_state_nx = IDLE;
            end
            default: begin
                w_cnt_nx   = L_TRST;
                w_state_nx = LATCH;
            end
        endcase
    end

    // Line follows the state one clock later; reset clears it at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= LATCH;
            r_cnt   <= L_TRST;
            r_shift <= '0;
            r_bit   <= '0;
            r_line  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_shift <= w_shift_nx;
            r_bit   <= w_bit_nx;
            r_line  <= (r_state == HIGH);
        end
    end

endmodule

// File: rtl/unipolar_rz_multi.sv
// Multi-lane FIFO-buffered unipolar RZ transmitter top:
// converts phase times to clock counts and replicates the lane.
module unipolar_rz_multi
    import unipolar_rz_pkg::*;
#(
    parameter int  CHANNELS       = 4,
    parameter int  DATA_WIDTH     = 24,
    parameter int  FIFO_DEPTH     = 4,
    parameter bit  MSB_FIRST      = 1'b1,
    parameter real CLOCK_RATE     = 100e6,
    parameter real ZERO_HIGH_TIME = 0.40e-6,
    parameter real ZERO_LOW_TIME  = 0.85e-6,
    parameter real ONE_HIGH_TIME  = 0.80e-6,
    parameter real ONE_LOW_TIME   = 0.45e-6,
    parameter real RESET_TIME     = 50e-6
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data,
    input  logic [CHANNELS-1:0]            valid,
    output logic [CHANNELS-1:0]            ready,
    output logic [CHANNELS-1:0]            line,
    output logic [CHANNELS-1:0]            idle
);

    localparam int T0H  = time_to_cycles(CLOCK_RATE, ZERO_HIGH_TIME);
    localparam int T0L  = time_to_cycles(CLOCK_RATE, ZERO_LOW_TIME);
    localparam int T1H  = time_to_cycles(CLOCK_RATE, ONE_HIGH_TIME);
    localparam int T1L  = time_to_cycles(CLOCK_RATE, ONE_LOW_TIME);
    localparam int TRST = time_to_cycles(CLOCK_RATE, RESET_TIME);

    if (T0H < 1 || T0L < 1 || T1H < 1 || T1L < 1 || TRST < 1) begin : g_bad_timing
        $error("unipolar_rz_multi: every phase must last at least one clock");
    end

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("unipolar_rz_multi: FIFO_DEPTH must be a power of two >= 2");
    end

    if (CHANNELS < 1 || DATA_WIDTH < 1) begin : g_bad_shape
        $error("unipolar_rz_multi: CHANNELS and DATA_WIDTH must be >= 1");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        unipolar_rz_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH),
            .MSB_FIRST  (MSB_FIRST),
            .T0H        (T0H),
            .T0L        (T0L),
            .T1H        (T1H),
            .T1L        (T1L),
            .TRST       (TRST)
        ) u_lane (
            .clock   (clock),
            .reset_n (reset_n),
            .data    (data[c*DATA_WIDTH +: DATA_WIDTH]),
            .valid   (valid[c]),
            .ready   (ready[c]),
            .line    (line[c]),
            .idle    (idle[c])
        );
    end

endmodule

// File: doc/unipolar_rz_multi.md
# unipolar_rz_multi

Multi-channel, FIFO-buffered unipolar return-to-zero serial transmitter for WS2812-class LED strips and similar single-wire protocols. Each of `CHANNELS` independent lanes buffers words in its own FIFO and streams them back to back. Each lane inserts the latch/reset low period only when its FIFO runs dry. Bit order is configurable. The block sits between the pixel/frame engine, which pushes words over a valid/ready interface, and the output pins.

## Interface
- `CHANNELS`, 4: number of independent output lanes (≥1).
- `DATA_WIDTH`, 24: bits per word (≥1).
- `FIFO_DEPTH`, 4: words buffered per lane; power of two, ≥2.
- `MSB_FIRST`, 1: 1 transmits bit `DATA_WIDTH-1` first; 0 transmits bit 0 first.
- `CLOCK_RATE`, 100e6: clock frequency in Hz (real).
- `ZERO_HIGH_TIME`, 0.40e-6 / `ZERO_LOW_TIME`, 0.85e-6: phase durations in seconds for a 0 bit (real).
- `ONE_HIGH_TIME`, 0.80e-6 / `ONE_LOW_TIME`, 0.45e-6: phase durations in seconds for a 1 bit (real).
- `RESET_TIME`, 50e-6: latch low time in seconds (real).

- `clock`  in  1  sole clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data`  in  `CHANNELS*DATA_WIDTH`  word for lane c at `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `valid`  in  `CHANNELS`  per-lane write request.
- `ready`  out  `CHANNELS`  per-lane FIFO not full; a word is accepted on an edge where `valid[c] && ready[c]`.
- `line`  out  `CHANNELS`  serial outputs.
- `idle`  out  `CHANNELS`  lane has an empty FIFO, is in IDLE, and its latch period has elapsed.

## Operation
- Cycle counts are computed at elaboration as round(CLOCK_RATE×time): T0H, T0L, T1H, T1L, TRST. Elaboration fails (`$error`) if any count is <1.
- Counter width is `$clog2(max(all counts)+1)`.
- Per-lane states are IDLE, HIGH, LOW and LATCH.
- IDLE, FIFO non-empty: pop a word into the shift register and go to HIGH. Line goes 1 and the counter loads T1H or T0H according to the current bit.
- HIGH, counter expires: go to LOW. Line goes 0 and the counter loads T1L or T0L.
- LOW, counter expires, bits remain: shift and go to HIGH.
- LOW, counter expires, last bit done, FIFO non-empty: pop and go to HIGH in the same cycle. There is no gap between words.
- LOW, counter expires, last bit done, FIFO empty: go to LATCH and load TRST.
- LATCH: line stays 0. A word arriving during LATCH is buffered but not sent. On expiry the lane goes to IDLE.
- Each high or low phase lasts exactly its count in clock cycles.
- `ready[c]` is derived from registered FIFO occupancy only. A full FIFO refuses writes even if a pop happens on the same edge.
- Writes while `ready[c]` is low are ignored and do not corrupt the FIFO.
- Lanes share nothing but `clock` and `reset_n`; activity on one lane never affects another.

## Timing
- Reset values: `line`=0, `ready`=all 1, `idle`=all 0.
- On release of `reset_n`, every lane enters LATCH with TRST loaded, so the strip always sees a valid latch. `idle` rises after TRST cycles.
- Reset asserted mid-word: `line` drops to 0 immediately (asynchronously), FIFOs are flushed and the shift register is cleared. The partial word is lost.
- Latency: a word accepted on edge N into an empty, IDLE lane drives `line` high from edge N+2.
- Word length is the sum over its bits of (TxH+TxL). Consecutive buffered words are contiguous.
- `idle[c]` falls on the same edge the FIFO first becomes non-empty.

## Structure
- Package `unipolar_rz_pkg` holds:
  - the lane state enum `rz_state_t` (IDLE, HIGH, LOW, LATCH);
  - a `time_to_cycles(real rate, real t)` function;
  - a `max_count` helper used for counter width.
- Sub-module `unipolar_rz_lane` contains one FIFO, serializer, counter and FSM. The top level instantiates it `CHANNELS` times in a generate loop and slices `data`.

## Test plan
Common configuration: CHANNELS=2, DATA_WIDTH=24, FIFO_DEPTH=4, 100 MHz clock, default times, giving T0H=40, T0L=85, T1H=80, T1L=45, TRST=5000.
- Release reset with no writes -> `line`=0 for 5000 cycles, then `idle`=2'b11.
- Lane 0, one word 24'hA50000, MSB_FIRST=1 -> high pulses of 80,40,80,40,40,80,40,80 cycles; lows of 45 or 85 accordingly; total 3000 cycles; then 5000-cycle latch; `idle[0]` rises after it.
- Four words pushed back to back into lane 0 -> 4th accept leaves `ready[0]`=0. The 5th write is dropped. Exactly 4 words are emitted contiguously, then one latch.
- MSB_FIRST=0 with 24'h000001 -> first high pulse is 80 cycles and the remaining 23 are 40.
- Lane 1 streams while lane 0 is idle -> `line[0]` stays 0 and lane 1 timing is bit-identical to a solo run.
- Assert `reset_n` during bit 10 -> `line` is 0 immediately and the FIFO is empty. After release there is a 5000-cycle latch, and no remnant of the old word is sent.
